// File: rtl/data_shifter_left.sv
// rtl/data_shifter_left.sv - 16-bit to 24-bit sign-extending left shifter with saturation and elastic FIFO
module data_shifter_left #(
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enn,
  input  logic [15:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [23:0]                data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       sat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [23:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               push;
  logic               pop;
  logic signed [39:0] wide;
  logic [23:0]        conv;
  logic               clip;

  assign in_ready   = (count != CW'(DEPTH));
  assign out_valid  = (count != '0);
  assign data_out   = out_valid ? mem[rd_ptr] : 24'h000000;
  assign fifo_count = count;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  // 40 bits holds a 16-bit sample shifted by up to 12 with room to detect overflow
  always_comb begin
    wide = $signed({{24{in_data[15]}}, in_data}) <<< SHIFT;
    clip = 1'b0;
    conv = wide[23:0];
    if (!enn) begin
      conv = 24'h000000;
    end else if (wide > 40'sd8388607) begin
      conv = 24'h7FFFFF;
      clip = 1'b1;
    end else if (wide < -40'sd8388608) begin
      conv = 24'h800000;
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= conv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sat    <= 1'b0;
    end else begin
      sat <= push && clip;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_shifter_left.sv
// tb/tb_data_shifter_left.sv - scoreboard bench for data_shifter_left at SHIFT=8 and SHIFT=10
module tb_data_shifter_left;

  logic        clk = 1'b0;
  logic        rst;
  logic        enn;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clip;

  logic        in_valid8, in_ready8, out_valid8, sat8;
  logic [23:0] data8;
  logic [2:0]  count8;
  logic        in_valid10, in_ready10, out_valid10, sat10;
  logic [23:0] data10;
  logic [2:0]  count10;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] q8[$];
  logic [23:0] q10[$];
  logic        pend8  = 1'b0;
  logic        pend10 = 1'b0;

  always #5 clk = ~clk;

  data_shifter_left #(.SHIFT(8), .DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .enn(enn), .in_data(in_data), .in_valid(in_valid8),
    .in_ready(in_ready8), .data_out(data8), .out_valid(out_valid8),
    .out_ready(out_ready), .fifo_count(count8), .sat(sat8)
  );

  data_shifter_left #(.SHIFT(10), .DEPTH(4)) dut10 (
    .clk(clk), .rst(rst), .enn(enn), .in_data(in_data), .in_valid(in_valid10),
    .in_ready(in_ready10), .data_out(data10), .out_valid(out_valid10),
    .out_ready(out_ready), .fifo_count(count10), .sat(sat10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the scoreboard on every consumed output, track the sat pulse one cycle after a push
  always @(negedge clk) begin
    if (rst) begin
      pend8 <= 1'b0;
    end else begin
      check("sat8", {31'd0, sat8}, {31'd0, pend8});
      pend8 <= in_valid8 && in_ready8 && enn && clip;
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) check("unexpected8", {8'd0, data8}, 32'hDEAD);
        else check("data8", {8'd0, data8}, {8'd0, q8.pop_front()});
      end else if (!out_valid8) begin
        check("empty_data8", {8'd0, data8}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pend10 <= 1'b0;
    end else begin
      check("sat10", {31'd0, sat10}, {31'd0, pend10});
      pend10 <= in_valid10 && in_ready10 && enn && clip;
      if (out_valid10 && out_ready) begin
        if (q10.size() == 0) check("unexpected10", {8'd0, data10}, 32'hDEAD);
        else check("data10", {8'd0, data10}, {8'd0, q10.pop_front()});
      end else if (!out_valid10) begin
        check("empty_data10", {8'd0, data10}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [15:0] d, input logic [23:0] e, input logic c);
    logic acc;
    in_data = d; clip = c; in_valid8 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready8;
      tick();
      if (acc) begin
        q8.push_back(e);
        in_valid8 = 1'b0;
        return;
      end
    end
    in_valid8 = 1'b0;
    check("timeout8", 32'd0, 32'd1);
  endtask

  task automatic send10(input logic [15:0] d, input logic [23:0] e, input logic c);
    logic acc;
    in_data = d; clip = c; in_valid10 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready10;
      tick();
      if (acc) begin
        q10.push_back(e);
        in_valid10 = 1'b0;
        return;
      end
    end
    in_valid10 = 1'b0;
    check("timeout10", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; enn = 1'b1; in_data = '0; clip = 1'b0;
    in_valid8 = 1'b0; in_valid10 = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", {29'd0, count8}, 32'd0);
    check("rst_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_data", {8'd0, data8}, 32'd0);
    check("rst_ready", {31'd0, in_ready8}, 32'd1);
    check("rst_sat", {31'd0, sat8}, 32'd0);

    // Basic expansion, one output per cycle
    out_ready = 1'b1;
    send8(16'h1234, 24'h123400, 1'b0);
    check("latency", {31'd0, out_valid8}, 32'd1);
    send8(16'h8000, 24'h800000, 1'b0);
    send8(16'hFFFF, 24'hFFFF00, 1'b0);
    repeat (3) tick();

    // Saturation and its boundaries at SHIFT=10
    send10(16'h4000, 24'h7FFFFF, 1'b1);
    send10(16'hC000, 24'h800000, 1'b1);
    send10(16'h0100, 24'h040000, 1'b0);
    send10(16'h1FFF, 24'h7FFC00, 1'b0);
    send10(16'h2000, 24'h7FFFFF, 1'b1);
    send10(16'hE000, 24'h800000, 1'b0);
    send10(16'hDFFF, 24'h800000, 1'b1);
    repeat (3) tick();

    // Fill with backpressure, then drain
    out_ready = 1'b0;
    send8(16'h0001, 24'h000100, 1'b0);
    send8(16'h0002, 24'h000200, 1'b0);
    send8(16'h0003, 24'h000300, 1'b0);
    send8(16'h0004, 24'h000400, 1'b0);
    in_data = 16'h0005; in_valid8 = 1'b1;
    tick();
    in_data = 16'h0006;
    tick();
    check("full_count", {29'd0, count8}, 32'd4);
    check("full_ready", {31'd0, in_ready8}, 32'd0);
    check("full_hold", {8'd0, data8}, 32'h000100);
    in_valid8 = 1'b0;
    out_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      tick();
      check("drain_count", {29'd0, count8}, k);
    end
    check("drained_valid", {31'd0, out_valid8}, 32'd0);
    check("drained_data", {8'd0, data8}, 32'd0);

    // Simultaneous push and pop at count 2
    out_ready = 1'b0;
    send8(16'h0021, 24'h002100, 1'b0);
    send8(16'h0022, 24'h002200, 1'b0);
    check("two_count", {29'd0, count8}, 32'd2);
    out_ready = 1'b1;
    send8(16'h0023, 24'h002300, 1'b0);
    check("pushpop_count", {29'd0, count8}, 32'd2);
    send8(16'h0024, 24'h002400, 1'b0);
    check("pushpop_count", {29'd0, count8}, 32'd2);
    repeat (4) tick();

    // Ten continuous transfers wrap both pointers
    for (int i = 0; i < 10; i++) begin
      send8(16'h0030 + 16'(i), 24'h003000 + 24'(i * 256), 1'b0);
      check("stream_count", {29'd0, count8}, 32'd1);
    end
    repeat (3) tick();

    // Mute stores zero and suppresses sat
    enn = 1'b0;
    send8(16'h7FFF, 24'h000000, 1'b0);
    send10(16'h4000, 24'h000000, 1'b1);
    enn = 1'b1;
    send8(16'h0002, 24'h000200, 1'b0);
    repeat (3) tick();

    // Reset with samples queued
    out_ready = 1'b0;
    send8(16'h0011, 24'h001100, 1'b0);
    send8(16'h0012, 24'h001200, 1'b0);
    send8(16'h0013, 24'h001300, 1'b0);
    check("queued_count", {29'd0, count8}, 32'd3);
    rst = 1'b1;
    q8.delete();
    tick();
    rst = 1'b0;
    check("mid_rst_count", {29'd0, count8}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid8}, 32'd0);
    check("mid_rst_data", {8'd0, data8}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready8}, 32'd1);
    out_ready = 1'b1;
    send8(16'h0055, 24'h005500, 1'b0);

    for (int i = 0; i < 200 && (q8.size() != 0 || q10.size() != 0); i++) tick();
    tick();
    check("queue8_drained", q8.size(), 32'd0);
    check("queue10_drained", q10.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
